// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// General-purpose register file with two combinational read ports, one
// synchronous write port, optional write-to-read forwarding, an optional
// hardwired zero register, and a per-register pending-write scoreboard.
// Decode reserves a destination at issue and writeback releases it. Each
// read port reports whether its source still has a write outstanding.

module regfile_scoreboard #(
   parameter int WIDTH    = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [ADDR_W-1:0] Read_reg1,
   input  logic [ADDR_W-1:0] Read_reg2,
   output logic [WIDTH-1:0]  Read_data1,
   output logic [WIDTH-1:0]  Read_data2,
   output logic              Read_busy1,
   output logic              Read_busy2,
   input  logic              Reg_write,
   input  logic [ADDR_W-1:0] Write_reg,
   input  logic [WIDTH-1:0]  Write_data,
   input  logic              Issue_valid,
   input  logic [ADDR_W-1:0] Issue_reg,
   output logic              Issue_ready,
   output logic [ADDR_W:0]   Pending_count
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = ADDR_W + 1;

   logic [WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0] pending;

   logic write_zero;
   logic issue_zero;
   logic read1_zero;
   logic read2_zero;
   logic write_en;
   logic issue_sets;
   logic write_clears;

   // Register 0 is zero-forced only when ZERO_REG is enabled; these flags
   // make every later decision independent of that parameter.
   always_comb begin
      write_zero = (ZERO_REG != 0) && (Write_reg == '0);
      issue_zero = (ZERO_REG != 0) && (Issue_reg == '0);
      read1_zero = (ZERO_REG != 0) && (Read_reg1 == '0);
      read2_zero = (ZERO_REG != 0) && (Read_reg2 == '0);
   end

   // An issue can be taken whenever its destination has no write in flight.
   // Register 0 never becomes pending, so an issue to it is always taken and
   // simply does nothing.
   always_comb begin
      Issue_ready  = issue_zero ? 1'b1 : !pending[Issue_reg];
      write_en     = Reg_write && !write_zero;
      issue_sets   = Issue_valid && !issue_zero && !pending[Issue_reg];
      write_clears = write_en && pending[Write_reg];
   end

   // Register storage; a write to the zero-forced register is dropped.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[Write_reg] <= Write_data;
      end
   end

   // Scoreboard bits; the issue assignment follows the write so that a
   // same-cycle issue and write to one register leaves it pending.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pending <= '0;
      end else begin
         if (write_en) begin
            pending[Write_reg] <= 1'b0;
         end
         if (issue_sets) begin
            pending[Issue_reg] <= 1'b1;
         end
      end
   end

   // Running count of pending registers. A bit can only be set when it was
   // clear and only cleared when it was set, so the count tracks the bit
   // population without ever wrapping.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Pending_count <= '0;
      end else begin
         Pending_count <= Pending_count + CNT_W'(issue_sets) - CNT_W'(write_clears);
      end
   end

   // Read port 1: zero register first, then same-cycle forwarding, else
   // the stored value and its scoreboard bit.
   always_comb begin
      Read_data1 = regs[Read_reg1];
      Read_busy1 = pending[Read_reg1];
      if (read1_zero) begin
         Read_data1 = '0;
         Read_busy1 = 1'b0;
      end else if ((BYPASS != 0) && write_en && (Write_reg == Read_reg1)) begin
         Read_data1 = Write_data;
         Read_busy1 = 1'b0;
      end
   end

   // Read port 2: same priority as port 1.
   always_comb begin
      Read_data2 = regs[Read_reg2];
      Read_busy2 = pending[Read_reg2];
      if (read2_zero) begin
         Read_data2 = '0;
         Read_busy2 = 1'b0;
      end else if ((BYPASS != 0) && write_en && (Write_reg == Read_reg2)) begin
         Read_data2 = Write_data;
         Read_busy2 = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Drives a forwarding and a non-forwarding instance with the same inputs.
// Each stimulus cycle pushes the expected outputs, computed from a plain
// array model of the register file, onto a queue. A monitor pops the queue
// on every falling edge and compares the values against both instances.

module tb_regfile_scoreboard;

   logic        Clk;
   logic        Reset_n;
   logic [4:0]  Read_reg1;
   logic [4:0]  Read_reg2;
   logic        Reg_write;
   logic [4:0]  Write_reg;
   logic [31:0] Write_data;
   logic        Issue_valid;
   logic [4:0]  Issue_reg;

   logic [31:0] Read_data1;
   logic [31:0] Read_data2;
   logic        Read_busy1;
   logic        Read_busy2;
   logic        Issue_ready;
   logic [5:0]  Pending_count;

   logic [31:0] nb_read_data1;
   logic [31:0] nb_read_data2;
   logic        nb_read_busy1;
   logic        nb_read_busy2;
   logic        nb_issue_ready;
   logic [5:0]  nb_pending_count;

   int checks;
   int failures;

   typedef struct {
      string       tag;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] nd1;
      logic [31:0] nd2;
      logic        b1;
      logic        b2;
      logic        nb1;
      logic        nb2;
      logic        rdy;
      logic [5:0]  cnt;
   } exp_t;

   exp_t exp_q[$];

   bit [31:0] m_regs [32];
   bit        m_pend [32];

   regfile_scoreboard dut (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .Read_reg1     (Read_reg1),
      .Read_reg2     (Read_reg2),
      .Read_data1    (Read_data1),
      .Read_data2    (Read_data2),
      .Read_busy1    (Read_busy1),
      .Read_busy2    (Read_busy2),
      .Reg_write     (Reg_write),
      .Write_reg     (Write_reg),
      .Write_data    (Write_data),
      .Issue_valid   (Issue_valid),
      .Issue_reg     (Issue_reg),
      .Issue_ready   (Issue_ready),
      .Pending_count (Pending_count)
   );

   regfile_scoreboard #(.BYPASS(0)) dut_nb (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .Read_reg1     (Read_reg1),
      .Read_reg2     (Read_reg2),
      .Read_data1    (nb_read_data1),
      .Read_data2    (nb_read_data2),
      .Read_busy1    (nb_read_busy1),
      .Read_busy2    (nb_read_busy2),
      .Reg_write     (Reg_write),
      .Write_reg     (Write_reg),
      .Write_data    (Write_data),
      .Issue_valid   (Issue_valid),
      .Issue_reg     (Issue_reg),
      .Issue_ready   (nb_issue_ready),
      .Pending_count (nb_pending_count)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] time limit reached");
   end

   task automatic checkOutput(input string tag, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s.%s actual=%h expected=%h", tag, field, act, exp);
      end
   endtask

   function automatic void clearModel();
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
   endfunction

   function automatic void expRead(input logic [4:0] a, input bit byp,
                                   output logic [31:0] d, output logic b);
      if (a == 5'd0) begin
         d = '0;
         b = 1'b0;
      end else if (byp && Reset_n && Reg_write && (Write_reg == a)) begin
         d = Write_data;
         b = 1'b0;
      end else begin
         d = m_regs[a];
         b = m_pend[a];
      end
   endfunction

   function automatic logic [5:0] modelCount();
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'd0, m_pend[i]};
      end
      return n;
   endfunction

   function automatic void updateModel();
      bit accepted;
      accepted = Issue_valid && ((Issue_reg == 5'd0) || !m_pend[Issue_reg]);
      if (Reg_write && (Write_reg != 5'd0)) begin
         m_regs[Write_reg] = Write_data;
         m_pend[Write_reg] = 1'b0;
      end
      if (accepted && (Issue_reg != 5'd0)) begin
         m_pend[Issue_reg] = 1'b1;
      end
   endfunction

   task automatic setIdle();
      Read_reg1   = '0;
      Read_reg2   = '0;
      Reg_write   = 1'b0;
      Write_reg   = '0;
      Write_data  = '0;
      Issue_valid = 1'b0;
      Issue_reg   = '0;
   endtask

   // Called just after a rising edge with the inputs already driven. Pushes
   // the expected outputs for this cycle, optionally releases a reset pulse
   // after the falling-edge sample, then advances the model at the next edge.
   task automatic applyStimulus(input string tag, input bit pulse);
      exp_t e;
      if (!Reset_n) clearModel();
      e.tag = tag;
      expRead(Read_reg1, 1'b1, e.d1, e.b1);
      expRead(Read_reg2, 1'b1, e.d2, e.b2);
      expRead(Read_reg1, 1'b0, e.nd1, e.nb1);
      expRead(Read_reg2, 1'b0, e.nd2, e.nb2);
      e.rdy = (Issue_reg == 5'd0) || !m_pend[Issue_reg];
      e.cnt = modelCount();
      exp_q.push_back(e);
      if (pulse) begin
         @(negedge Clk);
         #1;
         Reset_n = 1'b1;
      end
      @(posedge Clk);
      if (Reset_n) updateModel();
      else clearModel();
      #1;
   endtask

   // Monitor: every falling edge with an outstanding expectation is compared.
   always @(negedge Clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput(e.tag, "data1",     Read_data1,             e.d1);
         checkOutput(e.tag, "data2",     Read_data2,             e.d2);
         checkOutput(e.tag, "busy1",     {31'd0, Read_busy1},    {31'd0, e.b1});
         checkOutput(e.tag, "busy2",     {31'd0, Read_busy2},    {31'd0, e.b2});
         checkOutput(e.tag, "ready",     {31'd0, Issue_ready},   {31'd0, e.rdy});
         checkOutput(e.tag, "count",     {26'd0, Pending_count}, {26'd0, e.cnt});
         checkOutput(e.tag, "nb_data1",  nb_read_data1,          e.nd1);
         checkOutput(e.tag, "nb_data2",  nb_read_data2,          e.nd2);
         checkOutput(e.tag, "nb_busy1",  {31'd0, nb_read_busy1}, {31'd0, e.nb1});
         checkOutput(e.tag, "nb_busy2",  {31'd0, nb_read_busy2}, {31'd0, e.nb2});
         checkOutput(e.tag, "nb_ready",  {31'd0, nb_issue_ready},   {31'd0, e.rdy});
         checkOutput(e.tag, "nb_count",  {26'd0, nb_pending_count}, {26'd0, e.cnt});
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      clearModel();
      setIdle();
      Reset_n = 1'b0;
      @(posedge Clk);
      #1;

      // Outputs while reset is held
      Read_reg1 = 5'd3;
      Read_reg2 = 5'd4;
      applyStimulus("in_reset", 1'b0);
      applyStimulus("in_reset", 1'b0);
      Reset_n = 1'b1;

      // Every register reads zero and idle after reset
      for (int i = 0; i < 32; i++) begin
         setIdle();
         Read_reg1 = 5'(i);
         Read_reg2 = 5'(31 - i);
         Issue_reg = 5'(i);
         applyStimulus("post_reset", 1'b0);
      end

      // Write reg 5 and read it the same cycle, then the next cycle
      setIdle();
      Reg_write  = 1'b1;
      Write_reg  = 5'd5;
      Write_data = 32'hDEADBEEF;
      Read_reg1  = 5'd5;
      Read_reg2  = 5'd5;
      applyStimulus("wr5_same", 1'b0);
      setIdle();
      Read_reg1 = 5'd5;
      applyStimulus("wr5_next", 1'b0);

      // Write and issue to register 0
      setIdle();
      Reg_write   = 1'b1;
      Write_reg   = 5'd0;
      Write_data  = 32'h12345678;
      Issue_valid = 1'b1;
      Issue_reg   = 5'd0;
      applyStimulus("zero_wr", 1'b0);
      setIdle();
      applyStimulus("zero_after", 1'b0);

      // Issue reg 7, retry while pending, then write it back
      setIdle();
      Issue_valid = 1'b1;
      Issue_reg   = 5'd7;
      Read_reg2   = 5'd7;
      applyStimulus("iss7", 1'b0);
      applyStimulus("iss7_again", 1'b0);
      setIdle();
      Reg_write  = 1'b1;
      Write_reg  = 5'd7;
      Write_data = 32'h000000A5;
      Read_reg1  = 5'd7;
      Issue_reg  = 5'd7;
      applyStimulus("wb7", 1'b0);
      setIdle();
      Read_reg1 = 5'd7;
      Issue_reg = 5'd7;
      applyStimulus("wb7_after", 1'b0);

      // Same-cycle issue and write to idle reg 9
      setIdle();
      Reg_write   = 1'b1;
      Write_reg   = 5'd9;
      Write_data  = 32'h00000055;
      Issue_valid = 1'b1;
      Issue_reg   = 5'd9;
      Read_reg1   = 5'd9;
      applyStimulus("iss_wr9", 1'b0);
      setIdle();
      Read_reg1 = 5'd9;
      Issue_reg = 5'd9;
      applyStimulus("iss_wr9_after", 1'b0);

      // Fill the scoreboard, then confirm every register refuses issue
      for (int i = 1; i < 32; i++) begin
         setIdle();
         Issue_valid = 1'b1;
         Issue_reg   = 5'(i);
         Read_reg1   = 5'(i);
         applyStimulus("fill", 1'b0);
      end
      for (int i = 1; i < 32; i++) begin
         setIdle();
         Issue_reg = 5'(i);
         Read_reg2 = 5'(i);
         applyStimulus("full", 1'b0);
      end

      // Drain by writing every register
      for (int i = 1; i < 32; i++) begin
         setIdle();
         Reg_write  = 1'b1;
         Write_reg  = 5'(i);
         Write_data = $urandom;
         Read_reg1  = 5'(i);
         Read_reg2  = 5'(32 - i);
         applyStimulus("drain", 1'b0);
      end

      // Build some state, then pulse reset between edges
      setIdle();
      Issue_valid = 1'b1;
      Issue_reg   = 5'd3;
      applyStimulus("pre_rst_iss3", 1'b0);
      Issue_reg   = 5'd4;
      applyStimulus("pre_rst_iss4", 1'b0);
      setIdle();
      Reg_write  = 1'b1;
      Write_reg  = 5'd10;
      Write_data = 32'h000000FF;
      applyStimulus("pre_rst_wr10", 1'b0);
      setIdle();
      Read_reg1 = 5'd10;
      Read_reg2 = 5'd3;
      Issue_reg = 5'd4;
      applyStimulus("pre_rst_state", 1'b0);
      Reset_n = 1'b0;
      applyStimulus("rst_pulse", 1'b1);
      applyStimulus("rst_after", 1'b0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         Read_reg1   = 5'($urandom);
         Read_reg2   = 5'($urandom);
         Reg_write   = 1'($urandom);
         Write_reg   = 5'($urandom);
         Write_data  = $urandom;
         Issue_valid = 1'($urandom);
         Issue_reg   = 5'($urandom);
         if ($urandom_range(3) == 0) Read_reg1 = Write_reg;
         if ($urandom_range(3) == 0) Read_reg2 = Issue_reg;
         if ($urandom_range(7) == 0) Issue_reg = Write_reg;
         applyStimulus("random", 1'b0);
      end

      setIdle();
      repeat (3) @(negedge Clk);
      #1;
      checkOutput("end", "queue_left", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
